// File: rtl/alu_execute_stage.sv
// alu_execute_stage: ID/EX pipeline register, ALU, beq/bne resolution and
// EX/MEM pipeline register of the pipelined RISC-V core.
// Optional feature macro: EX_FORWARD_EN (forward the EX/MEM result to the
// E-stage operands). Without it, operands come only from the ID/EX register.
module alu_execute_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StallE,
  input  logic            FlushE,
  input  logic            ValidD,
  input  logic [2:0]      ALUControlD,
  input  logic [2:0]      funct3D,
  input  logic            BranchD,
  input  logic            RegWriteD,
  input  logic            ALUSrcD,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  input  logic [4:0]      RdD,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [XLEN-1:0] PCD,
  output logic            ValidM,
  output logic            RegWriteM,
  output logic [4:0]      RdM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic            BranchTakenE,
  output logic [XLEN-1:0] PCTargetE
);

`ifdef EX_FORWARD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            branch;
    logic            alu_src;
    logic [2:0]      alu_ctl;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
  } id_ex_t;

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic [4:0]      rd;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] write_data;
  } ex_mem_t;

  id_ex_t  id_ex_d, id_ex_q;
  ex_mem_t ex_mem_d, ex_mem_q;

  logic            fwd_a, fwd_b;
  logic [XLEN-1:0] rd2_fwd;
  logic [XLEN-1:0] src_a, src_b;
  logic [XLEN-1:0] alu_result_e;
  logic            zero_e;

  // ID/EX next value: flush beats stall, stall holds, otherwise capture decode
  always_comb begin
    id_ex_d = id_ex_q;
    if (FlushE) begin
      id_ex_d = '0;
    end else if (!StallE) begin
      id_ex_d.valid     = ValidD;
      id_ex_d.reg_write = RegWriteD;
      id_ex_d.branch    = BranchD;
      id_ex_d.alu_src   = ALUSrcD;
      id_ex_d.alu_ctl   = ALUControlD;
      id_ex_d.funct3    = funct3D;
      id_ex_d.rs1       = Rs1D;
      id_ex_d.rs2       = Rs2D;
      id_ex_d.rd        = RdD;
      id_ex_d.rd1       = RD1D;
      id_ex_d.rd2       = RD2D;
      id_ex_d.imm       = ImmExtD;
      id_ex_d.pc        = PCD;
    end
  end

  // ID/EX register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) id_ex_q <= '0;
    else        id_ex_q <= id_ex_d;
  end

  // Operand selection; the M-stage result replaces a stale register value
  // when forwarding is built in (never for x0)
  always_comb begin
    fwd_a = FwdEn & ex_mem_q.valid & ex_mem_q.reg_write & (ex_mem_q.rd != 5'd0)
            & (ex_mem_q.rd == id_ex_q.rs1);
    fwd_b = FwdEn & ex_mem_q.valid & ex_mem_q.reg_write & (ex_mem_q.rd != 5'd0)
            & (ex_mem_q.rd == id_ex_q.rs2);
    src_a   = fwd_a ? ex_mem_q.alu_result : id_ex_q.rd1;
    rd2_fwd = fwd_b ? ex_mem_q.alu_result : id_ex_q.rd2;
    src_b   = id_ex_q.alu_src ? id_ex_q.imm : rd2_fwd;
  end

  // ALU; unused codes yield zero
  always_comb begin
    alu_result_e = '0;
    case (id_ex_q.alu_ctl)
      3'b000:  alu_result_e = src_a + src_b;
      3'b001:  alu_result_e = src_a - src_b;
      3'b010:  alu_result_e = src_a & src_b;
      3'b011:  alu_result_e = src_a | src_b;
      3'b101:  alu_result_e[0] = $signed(src_a) < $signed(src_b);
      default: alu_result_e = '0;
    endcase
  end

  // Branch resolution and target
  always_comb begin
    zero_e       = (alu_result_e == '0);
    BranchTakenE = id_ex_q.valid & id_ex_q.branch &
                   (((id_ex_q.funct3 == 3'b000) & zero_e) |
                    ((id_ex_q.funct3 == 3'b001) & ~zero_e));
    PCTargetE    = id_ex_q.pc + id_ex_q.imm;
  end

  // EX/MEM next value: a stall pushes a bubble into M
  always_comb begin
    ex_mem_d = ex_mem_q;
    if (StallE) begin
      ex_mem_d.valid     = 1'b0;
      ex_mem_d.reg_write = 1'b0;
    end else begin
      ex_mem_d.valid      = id_ex_q.valid;
      ex_mem_d.reg_write  = id_ex_q.reg_write & id_ex_q.valid;
      ex_mem_d.rd         = id_ex_q.rd;
      ex_mem_d.alu_result = alu_result_e;
      ex_mem_d.write_data = rd2_fwd;
    end
  end

  // EX/MEM register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_mem_q <= '0;
    else        ex_mem_q <= ex_mem_d;
  end

  assign ValidM     = ex_mem_q.valid;
  assign RegWriteM  = ex_mem_q.reg_write;
  assign RdM        = ex_mem_q.rd;
  assign ALUResultM = ex_mem_q.alu_result;
  assign WriteDataM = ex_mem_q.write_data;

endmodule

// File: tb/tb_alu_execute_stage.sv
// Directed bench for alu_execute_stage: vector table plus hand-written
// reset, stall, flush and forwarding sequences.
module tb_alu_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StallE, FlushE, ValidD;
  logic [2:0]  ALUControlD, funct3D;
  logic        BranchD, RegWriteD, ALUSrcD;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic [31:0] RD1D, RD2D, ImmExtD, PCD;
  logic        ValidM, RegWriteM, BranchTakenE;
  logic [4:0]  RdM;
  logic [31:0] ALUResultM, WriteDataM, PCTargetE;

  int checks = 0;
  int errors = 0;

  alu_execute_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
    .ALUControlD(ALUControlD), .funct3D(funct3D), .BranchD(BranchD),
    .RegWriteD(RegWriteD), .ALUSrcD(ALUSrcD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD),
    .ValidM(ValidM), .RegWriteM(RegWriteM), .RdM(RdM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .BranchTakenE(BranchTakenE), .PCTargetE(PCTargetE)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        valid;
    logic [2:0]  ctl;
    logic [2:0]  f3;
    logic        br, rw, src;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rd1, rd2, imm, pc;
    logic [31:0] exp_res, exp_wd, exp_tgt;
    logic        exp_taken, exp_vm, exp_rwm;
  } vec_t;

  function automatic vec_t mk(input string name, input logic valid, input logic [2:0] ctl,
                              input logic [2:0] f3, input logic br, input logic rw,
                              input logic src, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic [31:0] rd1,
                              input logic [31:0] rd2, input logic [31:0] imm,
                              input logic [31:0] pc, input logic [31:0] exp_res,
                              input logic [31:0] exp_wd, input logic [31:0] exp_tgt,
                              input logic exp_taken, input logic exp_vm, input logic exp_rwm);
    vec_t v;
    v.name = name; v.valid = valid; v.ctl = ctl; v.f3 = f3; v.br = br; v.rw = rw;
    v.src = src; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.rd1 = rd1; v.rd2 = rd2;
    v.imm = imm; v.pc = pc; v.exp_res = exp_res; v.exp_wd = exp_wd; v.exp_tgt = exp_tgt;
    v.exp_taken = exp_taken; v.exp_vm = exp_vm; v.exp_rwm = exp_rwm;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ValidD = v.valid; ALUControlD = v.ctl; funct3D = v.f3; BranchD = v.br;
    RegWriteD = v.rw; ALUSrcD = v.src; Rs1D = v.rs1; Rs2D = v.rs2; RdD = v.rd;
    RD1D = v.rd1; RD2D = v.rd2; ImmExtD = v.imm; PCD = v.pc;
  endtask

  task automatic bubble();
    ValidD = 1'b0; ALUControlD = 3'b0; funct3D = 3'b0; BranchD = 1'b0;
    RegWriteD = 1'b0; ALUSrcD = 1'b0; Rs1D = 5'd0; Rs2D = 5'd0; RdD = 5'd0;
    RD1D = '0; RD2D = '0; ImmExtD = '0; PCD = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // add with register operands (or immediate when src=1)
  function automatic vec_t add_i(input logic [4:0] rs1, input logic [4:0] rd,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic src, input logic [31:0] pc);
    return mk("add", 1'b1, 3'b000, 3'b000, 1'b0, 1'b1, src, rs1, 5'd0, rd,
              a, src ? 32'h0 : b, src ? b : 32'h0, pc, 0, 0, 0, 0, 0, 0);
  endfunction

  vec_t vecs[13];
  logic [31:0] fwd_exp;

  initial begin
    vecs[0]  = mk("add_wrap",   1, 3'b000, 3'b000, 0, 1, 0, 5'd1, 5'd2, 5'd3,
                  32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0,
                  32'h0, 32'h1, 32'h0, 0, 1, 1);
    vecs[1]  = mk("sub_neg",    1, 3'b001, 3'b000, 0, 1, 0, 5'd1, 5'd2, 5'd4,
                  32'h5, 32'h7, 32'h4, 32'h10,
                  32'hFFFF_FFFE, 32'h7, 32'h14, 0, 1, 1);
    vecs[2]  = mk("slt_m1_1",   1, 3'b101, 3'b000, 0, 1, 0, 5'd1, 5'd2, 5'd5,
                  32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0,
                  32'h1, 32'h1, 32'h0, 0, 1, 1);
    vecs[3]  = mk("and",        1, 3'b010, 3'b000, 0, 1, 0, 5'd1, 5'd2, 5'd6,
                  32'hF0F0, 32'h0FF0, 32'h0, 32'h0,
                  32'h00F0, 32'h0FF0, 32'h0, 0, 1, 1);
    vecs[4]  = mk("code111",    1, 3'b111, 3'b000, 0, 1, 0, 5'd1, 5'd2, 5'd7,
                  32'h1234, 32'h55, 32'h0, 32'h0,
                  32'h0, 32'h55, 32'h0, 0, 1, 1);
    vecs[5]  = mk("beq_eq",     1, 3'b001, 3'b000, 1, 0, 0, 5'd1, 5'd2, 5'd0,
                  32'h9, 32'h9, 32'h20, 32'h100,
                  32'h0, 32'h9, 32'h120, 1, 1, 0);
    vecs[6]  = mk("bne_eq",     1, 3'b001, 3'b001, 1, 0, 0, 5'd1, 5'd2, 5'd0,
                  32'h9, 32'h9, 32'h20, 32'h100,
                  32'h0, 32'h9, 32'h120, 0, 1, 0);
    vecs[7]  = mk("beq_inval",  0, 3'b001, 3'b000, 1, 0, 0, 5'd1, 5'd2, 5'd0,
                  32'h9, 32'h9, 32'h20, 32'h100,
                  32'h0, 32'h9, 32'h120, 0, 0, 0);
    vecs[8]  = mk("or_imm",     1, 3'b011, 3'b000, 0, 1, 1, 5'd1, 5'd2, 5'd8,
                  32'h1000, 32'hDEAD, 32'hFF, 32'h0,
                  32'h10FF, 32'hDEAD, 32'hFF, 0, 1, 1);
    vecs[9]  = mk("bne_ne",     1, 3'b001, 3'b001, 1, 0, 0, 5'd1, 5'd2, 5'd0,
                  32'h5, 32'h3, 32'hFFFF_FFF0, 32'h200,
                  32'h2, 32'h3, 32'h1F0, 1, 1, 0);
    vecs[10] = mk("slt_1_m1",   1, 3'b101, 3'b000, 0, 1, 0, 5'd1, 5'd2, 5'd9,
                  32'h1, 32'hFFFF_FFFF, 32'h0, 32'h0,
                  32'h0, 32'hFFFF_FFFF, 32'h0, 0, 1, 1);
    vecs[11] = mk("code100_f3", 1, 3'b100, 3'b010, 1, 0, 0, 5'd1, 5'd2, 5'd0,
                  32'h7, 32'h7, 32'h8, 32'h8,
                  32'h0, 32'h7, 32'h10, 0, 1, 0);
    vecs[12] = mk("rw_inval",   0, 3'b000, 3'b000, 0, 1, 0, 5'd1, 5'd2, 5'd10,
                  32'h2, 32'h3, 32'h0, 32'h0,
                  32'h5, 32'h3, 32'h0, 0, 0, 0);

    // Reset held with random decode inputs
    rst_n = 1'b0; StallE = 1'b0; FlushE = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ValidD = 1'($urandom); ALUControlD = 3'($urandom); funct3D = 3'($urandom);
      BranchD = 1'($urandom); RegWriteD = 1'($urandom); ALUSrcD = 1'($urandom);
      Rs1D = 5'($urandom); Rs2D = 5'($urandom); RdD = 5'($urandom);
      RD1D = $urandom; RD2D = $urandom; ImmExtD = $urandom; PCD = $urandom;
      tick();
    end
    chk("rst_validm", 32'(ValidM), 32'h0);
    chk("rst_regwritem", 32'(RegWriteM), 32'h0);
    chk("rst_rdm", 32'(RdM), 32'h0);
    chk("rst_alum", ALUResultM, 32'h0);
    chk("rst_wdm", WriteDataM, 32'h0);
    chk("rst_taken", 32'(BranchTakenE), 32'h0);

    // First instruction after release reaches M after two edges
    drive(add_i(5'd1, 5'd7, 32'h1, 32'h2, 1'b0, 32'h0));
    rst_n = 1'b1;
    tick();
    bubble();
    chk("rel_edge1_validm", 32'(ValidM), 32'h0);
    tick();
    chk("rel_edge2_validm", 32'(ValidM), 32'h1);
    chk("rel_edge2_res", ALUResultM, 32'h3);
    chk("rel_edge2_rd", 32'(RdM), 32'd7);
    tick();

    // Vector table
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i]);
      tick();
      chk({vecs[i].name, "_taken"}, 32'(BranchTakenE), 32'(vecs[i].exp_taken));
      chk({vecs[i].name, "_target"}, PCTargetE, vecs[i].exp_tgt);
      bubble();
      tick();
      chk({vecs[i].name, "_validm"}, 32'(ValidM), 32'(vecs[i].exp_vm));
      chk({vecs[i].name, "_regwritem"}, 32'(RegWriteM), 32'(vecs[i].exp_rwm));
      chk({vecs[i].name, "_rdm"}, 32'(RdM), 32'(vecs[i].rd));
      chk({vecs[i].name, "_result"}, ALUResultM, vecs[i].exp_res);
      chk({vecs[i].name, "_wdata"}, WriteDataM, vecs[i].exp_wd);
    end

    // Two-cycle stall mid-stream: A, B, C back to back
    drive(add_i(5'd0, 5'd1, 32'h1, 32'h1, 1'b0, 32'h1000));
    tick();
    drive(add_i(5'd0, 5'd2, 32'h2, 32'h2, 1'b0, 32'h2000));
    tick();
    chk("stl_a_validm", 32'(ValidM), 32'h1);
    chk("stl_a_res", ALUResultM, 32'h2);
    drive(add_i(5'd0, 5'd3, 32'h3, 32'h3, 1'b0, 32'h3000));
    StallE = 1'b1;
    tick();
    chk("stl1_validm", 32'(ValidM), 32'h0);
    chk("stl1_e_hold", PCTargetE, 32'h2000);
    tick();
    chk("stl2_validm", 32'(ValidM), 32'h0);
    chk("stl2_e_hold", PCTargetE, 32'h2000);
    StallE = 1'b0;
    tick();
    chk("stl_b_validm", 32'(ValidM), 32'h1);
    chk("stl_b_res", ALUResultM, 32'h4);
    chk("stl_b_rd", 32'(RdM), 32'd2);
    chk("stl_c_in_e", PCTargetE, 32'h3000);
    bubble();
    tick();
    chk("stl_c_validm", 32'(ValidM), 32'h1);
    chk("stl_c_res", ALUResultM, 32'h6);
    chk("stl_c_rd", 32'(RdM), 32'd3);
    tick();
    chk("stl_end_validm", 32'(ValidM), 32'h0);

    // Flush together with stall empties E and bubbles M
    drive(mk("beq_x", 1, 3'b001, 3'b000, 1, 0, 0, 5'd1, 5'd2, 5'd0,
             32'h4, 32'h4, 32'h8, 32'h40, 0, 0, 0, 0, 0, 0));
    tick();
    chk("fl_x_taken", 32'(BranchTakenE), 32'h1);
    chk("fl_x_target", PCTargetE, 32'h48);
    drive(add_i(5'd0, 5'd4, 32'h1, 32'h1, 1'b0, 32'h80));
    StallE = 1'b1; FlushE = 1'b1;
    tick();
    chk("fl_taken", 32'(BranchTakenE), 32'h0);
    chk("fl_target", PCTargetE, 32'h0);
    chk("fl_validm", 32'(ValidM), 32'h0);
    StallE = 1'b0; FlushE = 1'b0;
    bubble();
    tick();
    chk("fl_next_validm", 32'(ValidM), 32'h0);

    // Dependent pair x5 = 3 + 4 ; x6 = x5 + 1 with stale RD1D = 0
`ifdef EX_FORWARD_EN
    fwd_exp = 32'h8;
`else
    fwd_exp = 32'h1;
`endif
    drive(add_i(5'd1, 5'd5, 32'h3, 32'h4, 1'b0, 32'h0));
    tick();
    drive(add_i(5'd5, 5'd6, 32'h0, 32'h1, 1'b1, 32'h0));
    tick();
    bubble();
    tick();
    chk("fwd_x5_res", ALUResultM, fwd_exp);
    chk("fwd_x5_rd", 32'(RdM), 32'd6);

    // Same pattern through x0 must never forward
    drive(add_i(5'd1, 5'd0, 32'h3, 32'h4, 1'b0, 32'h0));
    tick();
    drive(add_i(5'd0, 5'd6, 32'h0, 32'h1, 1'b1, 32'h0));
    tick();
    bubble();
    tick();
    chk("fwd_x0_res", ALUResultM, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
